// File: rtl/csa_accum.sv
// csa_accum -- multi-operand unsigned accumulator using carry-save compression.
//
// One W-bit operand per cycle is folded into a redundant sum/carry pair by a
// single 3:2 compressor row, so the accumulate path has no carry chain. When
// the operand flagged 'last' is taken, the pair is resolved by a CHUNK-bit
// carry-propagate adder over NCH = ACC_W/CHUNK cycles. The result is then
// held on a valid/ready output until it is consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand 'a' is valid
//   in_ready   operand accepted (only while accumulating)
//   a          W-bit unsigned operand, zero-extended to ACC_W
//   last       'a' is the final operand of the frame
//   out_valid  sum/ovf are valid
//   out_ready  consumer takes the result
//   sum        total modulo 2^ACC_W
//   ovf        total >= 2^ACC_W
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACC   | accepting operands into the s/c pair
// ST_RESOLVE | propagating carries one chunk per cycle into res
// ST_DONE  | result presented, waiting for out_ready

module csa_accum #(
   parameter int W     = 8,
   parameter int ACC_W = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic             last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   localparam int NCH   = ACC_W / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_RESOLVE,
      ST_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   s_q, s_d;
   logic [ACC_W-1:0]   c_q, c_d;
   logic [ACC_W-1:0]   res_q, res_d;
   logic               cy_q, cy_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   x;
   logic [ACC_W-1:0]   maj;
   logic [CHUNK:0]     chunk_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         s_q     <= '0;
         c_q     <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         idx_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         idx_q   <= idx_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      c_d       = c_q;
      res_d     = res_q;
      cy_d      = cy_q;
      idx_d     = idx_q;
      ovf_d     = ovf_q;

      x         = ACC_W'(a);
      maj       = (s_q & c_q) | (s_q & x) | (c_q & x);
      chunk_sum = {1'b0, s_q[idx_q*CHUNK +: CHUNK]}
                + {1'b0, c_q[idx_q*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, cy_q};

      case (state_q)
         ST_ACC: begin
            if (in_valid) begin
               s_d = s_q ^ c_q ^ x;
               c_d = maj << 1;
               // Every term is non-negative, so a carry shifted out of the
               // top bit means the true total already reached 2^ACC_W.
               if (maj[ACC_W-1]) ovf_d = 1'b1;
               if (last) begin
                  state_d = ST_RESOLVE;
                  idx_d   = '0;
                  cy_d    = 1'b0;
               end
            end
         end
         ST_RESOLVE: begin
            res_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            cy_d = chunk_sum[CHUNK];
            if (idx_q == IDX_W'(NCH - 1)) begin
               if (chunk_sum[CHUNK]) ovf_d = 1'b1;
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               s_d     = '0;
               c_d     = '0;
               res_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   assign in_ready  = (state_q == ST_ACC);
   assign out_valid = (state_q == ST_DONE);
   assign sum       = res_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum -- directed checks of csa_accum with defaults
// (W=8, ACC_W=16, CHUNK=4, so NCH=4), plus a short run of random frames
// checked against a plain integer sum. Inputs change and outputs are
// sampled on the falling clock edge.

module tb_csa_accum;

   localparam int W     = 8;
   localparam int ACC_W = 16;
   localparam int CHUNK = 4;
   localparam int NCH   = ACC_W / CHUNK;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic             last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] sum;
   logic             ovf;

   int n_tests = 0;
   int n_fail  = 0;

   csa_accum #(.W(W), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .last      (last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; presents one operand for exactly one rising edge.
   task automatic push(input logic [W-1:0] v, input logic lst);
      in_valid = 1'b1;
      a        = v;
      last     = lst;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      last     = 1'b0;
   endtask

   task automatic push_n(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) push(v, (i == n - 1));
   endtask

   // Starts at the falling edge right after the last operand was taken.
   task automatic wait_result(input string tag);
      int lat;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, NCH);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic expect_result(input string tag, input logic [ACC_W-1:0] s_exp,
                                input logic o_exp);
      wait_result(tag);
      check({tag, "_sum"}, {16'd0, sum}, {16'd0, s_exp});
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, o_exp});
      handshake(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      last      = 1'b0;
      out_ready = 1'b0;

      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset while a result sits in DONE.
      push(8'd4, 1'b0);
      push(8'd5, 1'b1);
      wait_result("pre_rst");
      check("pre_rst_sum", {16'd0, sum}, 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_sum", {16'd0, sum}, 32'd0);
      check("async_rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      push(8'd1, 1'b0);
      push(8'd1, 1'b1);
      expect_result("after_rst", 16'd2, 1'b0);

      push(8'd3, 1'b0);
      push(8'd5, 1'b0);
      push(8'd7, 1'b1);
      expect_result("basic", 16'd15, 1'b0);

      push(8'd200, 1'b1);
      expect_result("single", 16'd200, 1'b0);

      // 257*255 = 65535, 258*255 = 65790 = 65536 + 254, 65535 + 1 = 65536.
      push_n(8'd255, 257);
      expect_result("ovf_edge_lo", 16'hFFFF, 1'b0);

      push_n(8'd255, 258);
      expect_result("ovf_edge_hi", 16'd254, 1'b1);

      for (int i = 0; i < 257; i++) push(8'd255, 1'b0);
      push(8'd1, 1'b1);
      expect_result("ovf_exact", 16'd0, 1'b1);

      // Backpressure: 100 + 200 = 300, extra operands must not be absorbed.
      push(8'd100, 1'b0);
      push(8'd200, 1'b1);
      wait_result("bp");
      in_valid = 1'b1;
      a        = 8'h55;
      last     = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_sum", {16'd0, sum}, 32'd300);
         check("bp_ovf", {31'd0, ovf}, 32'd0);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      last     = 1'b0;
      handshake("bp");
      push(8'h2A, 1'b1);
      expect_result("after_bp", 16'd42, 1'b0);

      // Reset during the second resolve cycle.
      push(8'd50, 1'b0);
      push(8'd60, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_sum", {16'd0, sum}, 32'd0);
      check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
      end
      push(8'd9, 1'b0);
      push(8'd9, 1'b1);
      expect_result("after_mid_rst", 16'd18, 1'b0);

      // Random frames with input gaps and output stalls.
      for (int f = 0; f < 20; f++) begin
         int unsigned total;
         int          n;
         logic [W-1:0] v;
         total = 0;
         n = (f % 5 == 0) ? int'($urandom_range(300, 600)) : int'($urandom_range(1, 20));
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            v = W'($urandom_range(0, 255));
            total += v;
            push(v, (i == n - 1));
         end
         wait_result("rand");
         check("rand_sum", {16'd0, sum}, total & 32'hFFFF);
         check("rand_ovf", {31'd0, ovf}, {31'd0, (total >= 32'd65536)});
         repeat ($urandom_range(0, 3)) @(negedge clk);
         check("rand_hold", {31'd0, out_valid}, 32'd1);
         handshake("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csa_accum.md
# csa_accum

Parametrised multi-operand accumulator built on carry-save compression. It accepts one W-bit unsigned operand per cycle and folds it into a redundant sum/carry pair with a single 3:2 compressor row, so there is no carry chain in the accumulate path. When the frame's last operand arrives, it resolves the redundant pair with a chunked carry-propagate adder over several cycles. It then presents the ACC_W-bit result and an overflow flag on a valid/ready output. It is the sequential, arbitrary-operand-count successor to the team's fixed three-operand carry-save adder.

## Interface
- W, default 8: operand width.
- ACC_W, default 16: accumulator/result width. Must satisfy ACC_W ≥ W.
- CHUNK, default 4: bits resolved per cycle by the final adder. ACC_W must be a multiple of CHUNK. NCH = ACC_W/CHUNK.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand a is valid.
- in_ready  out  1  block accepts an operand (high only in ACC).
- a  in  W  unsigned operand, zero-extended to ACC_W.
- last  in  1  qualifies a: this is the final operand of the frame.
- out_valid  out  1  sum/ovf are valid.
- out_ready  in  1  consumer takes the result.
- sum  out  ACC_W  resolved total modulo 2^ACC_W.
- ovf  out  1  true total ≥ 2^ACC_W.

## Operation
- Registers:
  - s, c (ACC_W each), with accumulated value = s + c.
  - res (ACC_W).
  - cy (1-bit chunk carry).
  - idx (chunk index, 0..NCH-1).
  - ovf (sticky).
  - state.
- States: ACC, RESOLVE, DONE. Reset enters ACC.
- ACC: in_ready=1. On in_valid&in_ready, with x = zero-extended a:
  - s ← s^c^x.
  - m = (s&c)|(s&x)|(c&x); c ← {m[ACC_W-2:0],1'b0}.
  - If m[ACC_W-1]=1, set ovf. This is exact because all quantities are non-negative, so a dropped carry proves the total is ≥ 2^ACC_W.
  - If last=1 in the same transfer: go to RESOLVE with idx←0, cy←0.
- RESOLVE: in_ready=0. Each cycle:
  - {co, r} = s[idx*CHUNK +: CHUNK] + c[idx*CHUNK +: CHUNK] + cy.
  - res[idx chunk] ← r; cy ← co; idx ← idx+1.
  - On idx=NCH-1: if co=1, set ovf; go to DONE.
- DONE: out_valid=1; sum=res; ovf is final. Hold all outputs stable until out_ready=1. On that edge:
  - s, c, res, ovf ← 0; go to ACC.
- Inputs while in_ready=0 are ignored and not stored. There is no input bypass in the DONE→ACC cycle.
- A frame always contains ≥1 operand, since last travels with an operand. A single-operand frame yields sum = a.
- The arithmetic is unsigned only; there is no saturation.

## Timing
- Reset (rst_n low, asynchronous):
  - state=ACC; s, c, res, cy, idx, ovf = 0.
  - out_valid=0, sum=0, ovf=0, in_ready=1.
  - The reset takes effect immediately, including mid-RESOLVE or mid-DONE. Any partial frame is discarded.
- Accumulate throughput is 1 operand/cycle with no bubbles while in_valid=1.
- Latency: the last operand is accepted at edge k, and the RESOLVE cycles occupy edges k+1 … k+NCH.
  - out_valid is high from just after edge k+NCH.
  - With the defaults (NCH=4), the result is visible 4 cycles after the last operand is accepted.
- in_ready is low from edge k through the output handshake edge, and high again in the following cycle.
- out_valid deasserts on the edge where out_valid&out_ready=1.
- out_ready is ignored outside DONE.
- When CHUNK=ACC_W, RESOLVE takes 1 cycle.

## Test plan
- Reset: hold rst_n=0 mid-operation. Required: out_valid=0, sum=0, ovf=0, in_ready=1 asynchronously. After release, frame {1,1(last)} gives sum=2.
- Basic (W=8, ACC_W=16, CHUNK=4): send 3, 5, 7(last) on consecutive cycles. Required: out_valid 4 cycles after accepting 7, with sum=15, ovf=0.
- Overflow boundary:
  - 257 operands of 255 gives sum=65535, ovf=0.
  - 258 operands of 255 gives sum=254, ovf=1.
  - Frame {0xFFFF-style via many operands ending exactly at 65536} gives sum=0, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1. Required:
  - sum and ovf stay stable; in_ready=0; inputs are not absorbed.
  - Then complete the handshake; the next frame {0x2A(last)} gives sum=42.
- Reset mid-RESOLVE: assert rst_n=0 during the 2nd resolve cycle. Required: outputs clear immediately; no out_valid pulse follows; the next frame {9,9(last)} gives sum=18.
- Randomised config sweep (CHUNK∈{1,4,16}, ACC_W=16): random frames of 1–600 operands with random in_valid/out_ready gaps. Required: sum and ovf match a behavioural model, and latency equals NCH cycles.
